dac_par_seq: RTL and testbench
==============================

DAC_PAR_SEQ -- requirements
Module: dac_par_seq

Interface
REQ-001 The block SHALL take these parameters:
- DATA_W, 12: DAC data width.
- NUM_CH, 4: number of DAC channels.
- ADDR_W, 2: channel address width; NUM_CH <= 2**ADDR_W.
- CS_HOLD, 1: CS_N_O low time in clocks, >= 1.
- CLR_HOLD, 1: CLR_N_O low time in clocks, >= 1.

REQ-002 The block SHALL have these ports:
- FPGA_CLK_I, in, 1: single clock, 100 MHz.
- RESET_N_I, in, 1: reset, synchronous, active-low.
- VALID_I, in, 1: write request.
- READY_O, out, 1: write request accepted this cycle when VALID_I is also high.
- DATA_I, in, DATA_W: write data.
- ADDR_I, in, ADDR_W: target channel.
- MODE_I, in, 1: 0 = write and load immediately; 1 = deferred (stage only). Sampled with the request.
- LOAD_I, in, 1: issue one LDAC pulse for all staged channels.
- CLR_I, in, 1: clear DAC outputs.
- BUSY_O, out, 1: high when not IDLE.
- DONE_O, out, 1: one-cycle pulse when an operation completes.
- ERR_O, out, 1: one-cycle pulse when a write with ADDR_I >= NUM_CH is dropped.
- PENDING_O, out, NUM_CH: channels staged but not yet loaded.
- AD_O, out, ADDR_W: DAC address bus.
- DB_O, out, DATA_W: DAC data bus.
- RW_N_O, out, 1: DAC read/write strobe, active-low.
- CS_N_O, out, 1: DAC chip select, active-low.
- LDAC_N_O, out, 1: DAC load strobe, active-low.
- CLR_N_O, out, 1: DAC clear, active-low.

Function
REQ-003 The state machine SHALL have one-hot states IDLE, SETUP, CS, HOLD, LDAC and CLR.
REQ-004 All DAC pins SHALL be registered and SHALL reflect the current state with no extra cycle lag.
REQ-005 READY_O SHALL equal IDLE & !CLR_I & !LOAD_I.
REQ-006 Arbitration in IDLE SHALL follow fixed priority CLR_I > LOAD_I > VALID_I.
REQ-007 A write SHALL be accepted on the edge where VALID_I & READY_O are both high; ADDR_I, DATA_I and MODE_I SHALL be captured on that same edge.
REQ-008 An accepted write with ADDR_I >= NUM_CH SHALL pulse ERR_O next cycle, stay in IDLE, and SHALL NOT pulse DONE_O.
REQ-009 Write sequence:
- SETUP, 1 cycle: AD_O/DB_O driven, RW_N_O=0.
- CS, CS_HOLD cycles: CS_N_O=0, RW_N_O=0.
- HOLD, 1 cycle: CS_N_O=1, RW_N_O=0, AD_O/DB_O held.
- Then LDAC if MODE=0, else IDLE.
REQ-010 LDAC state SHALL be 1 cycle with LDAC_N_O=0, then go to IDLE.
REQ-011 LOAD_I in IDLE SHALL enter LDAC directly, even when PENDING_O=0.
REQ-012 CLR_I in IDLE SHALL enter CLR for CLR_HOLD cycles with CLR_N_O=0, then go to IDLE.
REQ-013 In all states, signals not explicitly driven low SHALL be high (inactive).
REQ-014 AD_O and DB_O SHALL change only on SETUP entry.
REQ-015 A deferred write SHALL set PENDING_O[addr].
REQ-016 Every LDAC state and every CLR state SHALL clear all PENDING_O bits on exit.
REQ-017 A write to an already-pending channel SHALL leave its bit set.
REQ-018 DONE_O SHALL pulse in the first IDLE cycle after HOLD (deferred), LDAC or CLR.
REQ-019 Latency with CS_HOLD=1, write accepted at edge t:
- SETUP at t+1, CS at t+2, HOLD at t+3.
- Immediate: LDAC at t+4, IDLE and DONE_O at t+5.
- Deferred: IDLE and DONE_O at t+4.
REQ-020 VALID_I, LOAD_I and CLR_I SHALL be ignored outside IDLE; requests are level-held by the master, not queued.
REQ-021 The hold counters SHALL reload to CS_HOLD or CLR_HOLD on state entry and SHALL NOT underflow.

Reset
REQ-022 While RESET_N_I=0 on an edge, the following SHALL be forced on that same edge, including mid-operation:
- State = IDLE.
- RW_N_O, CS_N_O, LDAC_N_O and CLR_N_O = 1.
- AD_O, DB_O and PENDING_O = 0.
- DONE_O and ERR_O = 0.
- READY_O SHALL be 0 during reset.
REQ-023 An operation interrupted by reset SHALL be abandoned: no DONE_O and no LDAC pulse.

Structure
REQ-024 Package dac_par_pkg SHALL hold the state encoding constants and the default timing constants.
REQ-025 Sub-module hold_timer (loadable down-counter with a zero flag) SHALL be instantiated for CS and for CLR.
REQ-026 Elaboration SHALL fail if CS_HOLD < 1, CLR_HOLD < 1, or NUM_CH > 2**ADDR_W.

Verification
REQ-027 Immediate write ADDR=2, DATA=0xABC, MODE=0 -> AD_O=2, DB_O=0xABC; CS_N_O low 1 cycle; LDAC_N_O low at t+4; DONE_O at t+5.
REQ-028 Deferred writes to ch0 and ch3, then LOAD_I -> PENDING_O=0b1001, then one LDAC pulse, then PENDING_O=0.
REQ-029 CLR_I and VALID_I asserted together in IDLE -> CLR_N_O low CLR_HOLD cycles, write not accepted, READY_O=0.
REQ-030 NUM_CH=3, write ADDR=3 -> ERR_O pulse, no CS_N_O activity, no DONE_O.
REQ-031 RESET_N_I=0 during CS state -> next edge all strobes=1, state IDLE, PENDING_O=0, no DONE_O.
REQ-032 CS_HOLD=4, back-to-back valid writes -> CS_N_O low exactly 4 cycles each; the next write is accepted only in IDLE.

Source files
------------

// File: rtl/dac_par_pkg.sv
// Shared constants for the parallel DAC write sequencer: state encoding,
// default geometry/timing and a counter width helper.
package dac_par_pkg;

    localparam int unsigned DEF_DATA_W   = 12;
    localparam int unsigned DEF_NUM_CH   = 4;
    localparam int unsigned DEF_ADDR_W   = 2;
    localparam int unsigned DEF_CS_HOLD  = 1;
    localparam int unsigned DEF_CLR_HOLD = 1;

    // One-hot sequencer states
    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StSetup = 6'b000010,
        StCs    = 6'b000100,
        StHold  = 6'b001000,
        StLdac  = 6'b010000,
        StClr   = 6'b100000
    } state_e;

    // Bits needed to hold values 0..max_val (at least 1)
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with a zero flag. Load has priority over decrement,
// and decrement saturates at zero so the count can never wrap.
module hold_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             FPGA_CLK_I,
    input  logic             RESET_N_I,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;

    // Count register: sync reset, reload, saturating decrement
    always_ff @(posedge FPGA_CLK_I) begin
        if (!RESET_N_I) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/dac_par_seq.sv
// Parallel-bus DAC write sequencer. Accepts channel writes (immediate or
// deferred), drives the DAC address/data bus and RW/CS/LDAC/CLR strobes,
// and tracks which channels hold staged-but-unloaded data.
module dac_par_seq
    import dac_par_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_CH   = DEF_NUM_CH,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
    parameter int unsigned CLR_HOLD = DEF_CLR_HOLD
) (
    input  logic              FPGA_CLK_I,
    input  logic              RESET_N_I,
    input  logic              VALID_I,
    output logic              READY_O,
    input  logic [DATA_W-1:0] DATA_I,
    input  logic [ADDR_W-1:0] ADDR_I,
    input  logic              MODE_I,
    input  logic              LOAD_I,
    input  logic              CLR_I,
    output logic              BUSY_O,
    output logic              DONE_O,
    output logic              ERR_O,
    output logic [NUM_CH-1:0] PENDING_O,
    output logic [ADDR_W-1:0] AD_O,
    output logic [DATA_W-1:0] DB_O,
    output logic              RW_N_O,
    output logic              CS_N_O,
    output logic              LDAC_N_O,
    output logic              CLR_N_O
);

    if (CS_HOLD < 1) begin : g_bad_cs_hold
        $error("dac_par_seq: CS_HOLD must be at least 1");
    end
    if (CLR_HOLD < 1) begin : g_bad_clr_hold
        $error("dac_par_seq: CLR_HOLD must be at least 1");
    end
    if (NUM_CH > (1 << ADDR_W)) begin : g_bad_num_ch
        $error("dac_par_seq: NUM_CH does not fit in ADDR_W address bits");
    end

    // Timers are loaded with HOLD-1: the state exits in the cycle the timer reads zero
    localparam int unsigned CS_W  = cnt_width(CS_HOLD);
    localparam int unsigned CLR_W = cnt_width(CLR_HOLD);
    localparam logic [CS_W-1:0]  CS_RELOAD  = CS_W'(CS_HOLD - 1);
    localparam logic [CLR_W-1:0] CLR_RELOAD = CLR_W'(CLR_HOLD - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] ad_q;
    logic [DATA_W-1:0] db_q;
    logic              mode_q;
    logic              rw_n_q, cs_n_q, ldac_n_q, clr_n_q;
    logic [NUM_CH-1:0] pending_q;
    logic              done_q, err_q;

    logic              addr_ok;
    logic [NUM_CH-1:0] chan_mask;
    logic              cs_load, cs_dec, cs_zero;
    logic              clr_load, clr_dec, clr_zero;

    assign addr_ok   = (32'(ADDR_I) < NUM_CH);
    assign chan_mask = NUM_CH'(1) << ad_q;

    // Timer reload coincides with the edge that enters CS / CLR
    assign cs_load  = (state_q == StSetup);
    assign cs_dec   = (state_q == StCs);
    assign clr_load = (state_q == StIdle) && CLR_I;
    assign clr_dec  = (state_q == StClr);

    hold_timer #(
        .WIDTH (CS_W)
    ) u_cs_timer (
        .FPGA_CLK_I (FPGA_CLK_I),
        .RESET_N_I  (RESET_N_I),
        .load       (cs_load),
        .load_val   (CS_RELOAD),
        .dec        (cs_dec),
        .zero       (cs_zero)
    );

    hold_timer #(
        .WIDTH (CLR_W)
    ) u_clr_timer (
        .FPGA_CLK_I (FPGA_CLK_I),
        .RESET_N_I  (RESET_N_I),
        .load       (clr_load),
        .load_val   (CLR_RELOAD),
        .dec        (clr_dec),
        .zero       (clr_zero)
    );

    // Sequencer: strobes are set on the same edge as the state they belong to
    always_ff @(posedge FPGA_CLK_I) begin
        if (!RESET_N_I) begin
            state_q   <= StIdle;
            ad_q      <= '0;
            db_q      <= '0;
            mode_q    <= 1'b0;
            rw_n_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            ldac_n_q  <= 1'b1;
            clr_n_q   <= 1'b1;
            pending_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (CLR_I) begin
                        state_q <= StClr;
                        clr_n_q <= 1'b0;
                    end else if (LOAD_I) begin
                        state_q  <= StLdac;
                        ldac_n_q <= 1'b0;
                    end else if (VALID_I) begin
                        if (addr_ok) begin
                            state_q <= StSetup;
                            ad_q    <= ADDR_I;
                            db_q    <= DATA_I;
                            mode_q  <= MODE_I;
                            rw_n_q  <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    state_q <= StCs;
                    cs_n_q  <= 1'b0;
                end
                StCs: begin
                    if (cs_zero) begin
                        state_q <= StHold;
                        cs_n_q  <= 1'b1;
                    end
                end
                StHold: begin
                    rw_n_q <= 1'b1;
                    if (mode_q) begin
                        state_q   <= StIdle;
                        done_q    <= 1'b1;
                        pending_q <= pending_q | chan_mask;
                    end else begin
                        state_q  <= StLdac;
                        ldac_n_q <= 1'b0;
                    end
                end
                StLdac: begin
                    state_q   <= StIdle;
                    ldac_n_q  <= 1'b1;
                    pending_q <= '0;
                    done_q    <= 1'b1;
                end
                StClr: begin
                    if (clr_zero) begin
                        state_q   <= StIdle;
                        clr_n_q   <= 1'b1;
                        pending_q <= '0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    rw_n_q   <= 1'b1;
                    cs_n_q   <= 1'b1;
                    ldac_n_q <= 1'b1;
                    clr_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign READY_O   = RESET_N_I && (state_q == StIdle) && !CLR_I && !LOAD_I;
    assign BUSY_O    = (state_q != StIdle);
    assign DONE_O    = done_q;
    assign ERR_O     = err_q;
    assign PENDING_O = pending_q;
    assign AD_O      = ad_q;
    assign DB_O      = db_q;
    assign RW_N_O    = rw_n_q;
    assign CS_N_O    = cs_n_q;
    assign LDAC_N_O  = ldac_n_q;
    assign CLR_N_O   = clr_n_q;

endmodule

// File: tb/tb_dac_par_seq.sv
// Bench for dac_par_seq: a default instance driven from a vector table and a
// second instance (NUM_CH=3, CS_HOLD=4, CLR_HOLD=3) driven by hand sequences.
module tb_dac_par_seq;

    // Strobe patterns {RW_N, CS_N, LDAC_N, CLR_N}
    localparam logic [3:0] S_IDLE = 4'b1111;
    localparam logic [3:0] S_WR   = 4'b0111;
    localparam logic [3:0] S_CS   = 4'b0011;
    localparam logic [3:0] S_LD   = 4'b1101;
    localparam logic [3:0] S_CL   = 4'b1110;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default instance
    logic        d_rst_n, d_valid, d_mode, d_load, d_clr;
    logic [1:0]  d_addr;
    logic [11:0] d_data;
    logic        d_ready, d_busy, d_done, d_err, d_rw_n, d_cs_n, d_ldac_n, d_clr_n;
    logic [3:0]  d_pend;
    logic [1:0]  d_ad;
    logic [11:0] d_db;
    logic [24:0] d_obs;
    assign d_obs = {d_busy, d_done, d_err, d_pend, d_ad, d_db, d_rw_n, d_cs_n, d_ldac_n, d_clr_n};

    // Alternate instance
    logic        a_rst_n, a_valid, a_mode, a_load, a_clr;
    logic [1:0]  a_addr;
    logic [11:0] a_data;
    logic        a_ready, a_busy, a_done, a_err, a_rw_n, a_cs_n, a_ldac_n, a_clr_n;
    logic [2:0]  a_pend;
    logic [1:0]  a_ad;
    logic [11:0] a_db;
    logic [23:0] a_obs;
    assign a_obs = {a_busy, a_done, a_err, a_pend, a_ad, a_db, a_rw_n, a_cs_n, a_ldac_n, a_clr_n};

    dac_par_seq #(
        .DATA_W   (12),
        .NUM_CH   (4),
        .ADDR_W   (2),
        .CS_HOLD  (1),
        .CLR_HOLD (1)
    ) u_dut (
        .FPGA_CLK_I (clk),
        .RESET_N_I  (d_rst_n),
        .VALID_I    (d_valid),
        .READY_O    (d_ready),
        .DATA_I     (d_data),
        .ADDR_I     (d_addr),
        .MODE_I     (d_mode),
        .LOAD_I     (d_load),
        .CLR_I      (d_clr),
        .BUSY_O     (d_busy),
        .DONE_O     (d_done),
        .ERR_O      (d_err),
        .PENDING_O  (d_pend),
        .AD_O       (d_ad),
        .DB_O       (d_db),
        .RW_N_O     (d_rw_n),
        .CS_N_O     (d_cs_n),
        .LDAC_N_O   (d_ldac_n),
        .CLR_N_O    (d_clr_n)
    );

    dac_par_seq #(
        .DATA_W   (12),
        .NUM_CH   (3),
        .ADDR_W   (2),
        .CS_HOLD  (4),
        .CLR_HOLD (3)
    ) u_alt (
        .FPGA_CLK_I (clk),
        .RESET_N_I  (a_rst_n),
        .VALID_I    (a_valid),
        .READY_O    (a_ready),
        .DATA_I     (a_data),
        .ADDR_I     (a_addr),
        .MODE_I     (a_mode),
        .LOAD_I     (a_load),
        .CLR_I      (a_clr),
        .BUSY_O     (a_busy),
        .DONE_O     (a_done),
        .ERR_O      (a_err),
        .PENDING_O  (a_pend),
        .AD_O       (a_ad),
        .DB_O       (a_db),
        .RW_N_O     (a_rw_n),
        .CS_N_O     (a_cs_n),
        .LDAC_N_O   (a_ldac_n),
        .CLR_N_O    (a_clr_n)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        valid;
        logic [1:0]  addr;
        logic [11:0] data;
        logic        mode;
        logic        load;
        logic        clr;
        logic        ready;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic rst_n, input logic valid,
                       input logic [1:0] addr, input logic [11:0] data, input logic mode,
                       input logic load, input logic clr, input logic ready, input logic busy,
                       input logic done, input logic [3:0] pend, input logic [1:0] ad,
                       input logic [11:0] db, input logic [3:0] strb);
        vec_t v;
        v.name  = name;
        v.rst_n = rst_n;
        v.valid = valid;
        v.addr  = addr;
        v.data  = data;
        v.mode  = mode;
        v.load  = load;
        v.clr   = clr;
        v.ready = ready;
        v.exp   = {busy, done, 1'b0, pend, ad, db, strb};
        vecs.push_back(v);
    endtask

    // Drive a row at the falling edge, check READY before the rising edge, outputs after it
    task automatic step(input vec_t v);
        @(negedge clk);
        d_rst_n = v.rst_n;
        d_valid = v.valid;
        d_addr  = v.addr;
        d_data  = v.data;
        d_mode  = v.mode;
        d_load  = v.load;
        d_clr   = v.clr;
        #1;
        check({v.name, "/ready"}, 64'(d_ready), 64'(v.ready));
        @(posedge clk);
        #1;
        check({v.name, "/outs"}, 64'(d_obs), 64'(v.exp));
    endtask

    task automatic a_set(input logic valid, input logic [1:0] addr, input logic [11:0] data,
                         input logic mode, input logic clr);
        a_valid = valid;
        a_addr  = addr;
        a_data  = data;
        a_mode  = mode;
        a_clr   = clr;
    endtask

    initial begin
        logic [13:0] cs_exp;
        logic [13:0] done_exp;
        logic [13:0] rdy_exp;
        logic [4:0]  clrn_exp;
        logic [4:0]  cdone_exp;
        int          events;

        d_rst_n = 1'b0; d_valid = 1'b0; d_addr = '0; d_data = '0;
        d_mode  = 1'b0; d_load  = 1'b0; d_clr  = 1'b0;
        a_rst_n = 1'b0; a_valid = 1'b0; a_addr = '0; a_data = '0;
        a_mode  = 1'b0; a_load  = 1'b0; a_clr  = 1'b0;

        // name rst v addr data mode ld cl | rdy busy done pend ad db strb
        add("imm_setup",   1, 1, 2, 12'hABC, 0, 0, 0, 1, 1, 0, 4'h0, 2, 12'hABC, S_WR);
        add("imm_cs",      1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h0, 2, 12'hABC, S_CS);
        add("imm_hold",    1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h0, 2, 12'hABC, S_WR);
        add("imm_ldac",    1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h0, 2, 12'hABC, S_LD);
        add("imm_done",    1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h0, 2, 12'hABC, S_IDLE);
        add("imm_idle",    1, 0, 0, 12'h000, 0, 0, 0, 1, 0, 0, 4'h0, 2, 12'hABC, S_IDLE);
        add("def0_setup",  1, 1, 0, 12'h111, 1, 0, 0, 1, 1, 0, 4'h0, 0, 12'h111, S_WR);
        add("def0_cs",     1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h0, 0, 12'h111, S_CS);
        add("def0_hold",   1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h0, 0, 12'h111, S_WR);
        add("def0_done",   1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h1, 0, 12'h111, S_IDLE);
        add("def3_setup",  1, 1, 3, 12'h333, 1, 0, 0, 1, 1, 0, 4'h1, 3, 12'h333, S_WR);
        add("def3_cs",     1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h1, 3, 12'h333, S_CS);
        add("def3_hold",   1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h1, 3, 12'h333, S_WR);
        add("def3_done",   1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h9, 3, 12'h333, S_IDLE);
        add("load_ldac",   1, 0, 0, 12'h000, 0, 1, 0, 0, 1, 0, 4'h9, 3, 12'h333, S_LD);
        add("load_done",   1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h0, 3, 12'h333, S_IDLE);
        add("load_idle",   1, 0, 0, 12'h000, 0, 0, 0, 1, 0, 0, 4'h0, 3, 12'h333, S_IDLE);
        add("clrwr_clr",   1, 1, 1, 12'h555, 0, 0, 1, 0, 1, 0, 4'h0, 3, 12'h333, S_CL);
        add("clrwr_done",  1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h0, 3, 12'h333, S_IDLE);
        add("eload_ldac",  1, 0, 0, 12'h000, 0, 1, 0, 0, 1, 0, 4'h0, 3, 12'h333, S_LD);
        add("eload_done",  1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h0, 3, 12'h333, S_IDLE);
        add("ldwr_ldac",   1, 1, 1, 12'h444, 0, 1, 0, 0, 1, 0, 4'h0, 3, 12'h333, S_LD);
        add("ldwr_done",   1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h0, 3, 12'h333, S_IDLE);
        add("clrld_clr",   1, 0, 0, 12'h000, 0, 1, 1, 0, 1, 0, 4'h0, 3, 12'h333, S_CL);
        add("clrld_done",  1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h0, 3, 12'h333, S_IDLE);
        add("rd2_setup",   1, 1, 2, 12'h222, 1, 0, 0, 1, 1, 0, 4'h0, 2, 12'h222, S_WR);
        add("rd2_cs",      1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h0, 2, 12'h222, S_CS);
        add("rd2_hold",    1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h0, 2, 12'h222, S_WR);
        add("rd2_done",    1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h4, 2, 12'h222, S_IDLE);
        add("rd2b_setup",  1, 1, 2, 12'h2A2, 1, 0, 0, 1, 1, 0, 4'h4, 2, 12'h2A2, S_WR);
        add("rd2b_cs",     1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h4, 2, 12'h2A2, S_CS);
        add("rd2b_hold",   1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h4, 2, 12'h2A2, S_WR);
        add("rd2b_done",   1, 0, 0, 12'h000, 0, 0, 0, 0, 0, 1, 4'h4, 2, 12'h2A2, S_IDLE);
        add("ri1_setup",   1, 1, 1, 12'h777, 0, 0, 0, 1, 1, 0, 4'h4, 1, 12'h777, S_WR);
        add("ri1_cs",      1, 0, 0, 12'h000, 0, 0, 0, 0, 1, 0, 4'h4, 1, 12'h777, S_CS);
        add("rst_in_cs",   0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 0, 4'h0, 0, 12'h000, S_IDLE);
        add("rst_after1",  1, 0, 0, 12'h000, 0, 0, 0, 1, 0, 0, 4'h0, 0, 12'h000, S_IDLE);
        add("rst_after2",  1, 0, 0, 12'h000, 0, 0, 0, 1, 0, 0, 4'h0, 0, 12'h000, S_IDLE);

        // Reset state of both instances, READY held low while in reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready_d", 64'(d_ready), 64'(0));
        check("reset_outs_d", 64'(d_obs), 64'({3'b000, 4'h0, 2'd0, 12'h000, S_IDLE}));
        check("reset_ready_a", 64'(a_ready), 64'(0));
        check("reset_outs_a", 64'(a_obs), 64'({3'b000, 3'h0, 2'd0, 12'h000, S_IDLE}));
        @(negedge clk);
        a_rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i]);

        // Alternate: out-of-range channel is dropped with a single ERR pulse
        @(negedge clk);
        a_set(1'b1, 2'd3, 12'hFFF, 1'b0, 1'b0);
        #1;
        check("err_ready", 64'(a_ready), 64'(1));
        @(posedge clk);
        #1;
        check("err_pulse", 64'(a_obs), 64'({3'b001, 3'h0, 2'd0, 12'h000, S_IDLE}));
        @(negedge clk);
        a_set(1'b0, 2'd0, 12'h000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("err_after", 64'(a_obs), 64'({3'b000, 3'h0, 2'd0, 12'h000, S_IDLE}));
        events = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (!a_cs_n || a_done || a_err || !a_rw_n) events++;
        end
        check("err_quiet", 64'(events), 64'(0));

        // Alternate: back-to-back deferred writes with VALID held, CS_HOLD=4
        cs_exp   = 14'b11000011100001;
        done_exp = 14'b10000001000000;
        rdy_exp  = 14'b10000001000000;
        @(negedge clk);
        a_set(1'b1, 2'd1, 12'h0AA, 1'b1, 1'b0);
        #1;
        check("b2b_ready0", 64'(a_ready), 64'(1));
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_cs_n[%0d]", k), 64'(a_cs_n), 64'(cs_exp[k]));
            check($sformatf("b2b_done[%0d]", k), 64'(a_done), 64'(done_exp[k]));
            if (k == 0) check("b2b_bus1", 64'({a_ad, a_db}), 64'({2'd1, 12'h0AA}));
            if (k == 7) check("b2b_bus2", 64'({a_ad, a_db}), 64'({2'd2, 12'h0BB}));
            @(negedge clk);
            if (k == 0) a_set(1'b1, 2'd2, 12'h0BB, 1'b1, 1'b0);
            if (k == 7) a_set(1'b0, 2'd0, 12'h000, 1'b0, 1'b0);
            #1;
            check($sformatf("b2b_ready[%0d]", k), 64'(a_ready), 64'(rdy_exp[k]));
        end
        check("b2b_pending", 64'(a_pend), 64'(3'b110));

        // Alternate: CLR held low CLR_HOLD=3 cycles; VALID during CLR is ignored
        clrn_exp  = 5'b11000;
        cdone_exp = 5'b01000;
        a_set(1'b0, 2'd0, 12'h000, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("clr_n[%0d]", k), 64'(a_clr_n), 64'(clrn_exp[k]));
            check($sformatf("clr_done[%0d]", k), 64'(a_done), 64'(cdone_exp[k]));
            if (k == 2) check("clr_pend_held", 64'(a_pend), 64'(3'b110));
            if (k == 3) check("clr_pend_clear", 64'(a_pend), 64'(3'b000));
            if (k == 3) check("clr_bus_kept", 64'({a_ad, a_db}), 64'({2'd2, 12'h0BB}));
            @(negedge clk);
            if (k == 0 || k == 1) a_set(1'b1, 2'd0, 12'h123, 1'b0, 1'b0);
            else a_set(1'b0, 2'd0, 12'h000, 1'b0, 1'b0);
            #1;
            if (k < 2) check($sformatf("clr_ready[%0d]", k), 64'(a_ready), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
